multibyte_add_seq: RTL
======================

MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit, the request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port A_in, input, 8*NBYTES bits, operand A.
REQ-006 SHALL have port B_in, input, 8*NBYTES bits, operand B.
REQ-007 SHALL have port Cin_in, input, 1 bit, the carry-in to the least significant byte.
REQ-008 SHALL have port A_byte, output, 8 bits, the current A byte driven to the external 8-bit ripple adder.
REQ-009 SHALL have port B_byte, output, 8 bits, the current B byte driven to the adder.
REQ-010 SHALL have port Cin_byte, output, 1 bit, the current carry driven to the adder's Cin.
REQ-011 SHALL have port S_byte, input, 8 bits, the sum returned by the adder (combinational path).
REQ-012 SHALL have port Cout_byte, input, 1 bit, the carry-out returned by the adder.
REQ-013 SHALL have port S_out, output, 8*NBYTES bits, the full result.
REQ-014 SHALL have port Cout_out, output, 1 bit, the final carry-out.
REQ-015 SHALL have port busy, output, 1 bit, high while in RUN.
REQ-016 SHALL have port done, output, 1 bit, a one-cycle pulse when the result is valid.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 Transitions SHALL be: IDLE with start=1 -> RUN; RUN with byte index = NBYTES-1 -> DONE; DONE -> IDLE unconditionally.
REQ-019 On an IDLE+start edge the block SHALL capture A_in and B_in into shift registers, load the carry register with Cin_in, and clear the byte index to 0.
REQ-020 In RUN, A_byte and B_byte SHALL be byte[index] of the captured operands and Cin_byte SHALL be the carry register.
REQ-021 Each RUN edge SHALL write S_byte into S_out byte[index], load Cout_byte into the carry register, and increment the index.
REQ-022 Exactly one byte SHALL be processed per cycle; RUN SHALL last exactly NBYTES cycles.
REQ-023 done SHALL be high for exactly one cycle, in DONE, NBYTES+1 cycles after the accepting start edge.
REQ-024 Cout_out SHALL equal the carry register; S_out and Cout_out SHALL hold their value from DONE until the next accepted start.
REQ-025 A start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-026 A_in, B_in and Cin_in changes after the capture edge SHALL NOT affect the result.
REQ-027 Outside RUN, A_byte, B_byte and Cin_byte SHALL be driven to 0.
REQ-028 Results SHALL wrap modulo 2^(8*NBYTES), with the overflow reported only on Cout_out.

Reset
REQ-029 On a rst=1 edge the block SHALL enter IDLE and clear to zero: index, carry register, S_out, Cout_out, busy, done and the operand registers.
REQ-030 rst SHALL take priority over start and over any in-flight operation: a reset mid-RUN aborts with no done pulse.
REQ-031 The first start SHALL be accepted on the first edge with rst=0 and start=1.

Configuration
REQ-032 With macro MULTIBYTE_SUB_EN defined, the block SHALL add an input port sub (1 bit, sampled with start).
REQ-033 With MULTIBYTE_SUB_EN defined and sub=1, the block SHALL capture ~B_in, load the carry register with 1 regardless of Cin_in, and compute A-B; Cout_out=1 then means no borrow.
REQ-034 Without MULTIBYTE_SUB_EN, the sub port SHALL be absent and the block SHALL only add.

Verification
REQ-035 NBYTES=4, A=0xFFFFFFFF, B=0x00000001, Cin=0, start -> done on cycle 5; S_out=0x00000000; Cout_out=1; Cin_byte observed as 0,1,1,1.
REQ-036 A=0x12345678, B=0x11111111, Cin=1 -> S_out=0x2345678A, Cout_out=0; busy high for exactly 4 cycles.
REQ-037 start pulsed again during RUN and during DONE -> ignored; exactly one done pulse; result unchanged.
REQ-038 rst asserted on the 2nd RUN cycle -> IDLE next cycle; all outputs 0; no done pulse; a following start completes normally.
REQ-039 With MULTIBYTE_SUB_EN defined, sub=1, A=0x00000005, B=0x00000007 -> S_out=0xFFFFFFFE, Cout_out=0; with A=7, B=5 -> S_out=0x00000002, Cout_out=1.
REQ-040 Back-to-back starts held high -> operations accepted every NBYTES+2 cycles, each producing the correct sum.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: byte-serial wide adder that drives an external 8-bit
// ripple adder, one byte per clock, LSB first.
// Optional feature: define MULTIBYTE_SUB_EN to add a 'sub' input that turns
// the operation into A-B (two's complement, Cout_out=1 means no borrow).
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef MULTIBYTE_SUB_EN
  input  logic                  sub,
`endif
  input  logic [8*NBYTES-1:0]   A_in,
  input  logic [8*NBYTES-1:0]   B_in,
  input  logic                  Cin_in,
  output logic [7:0]            A_byte,
  output logic [7:0]            B_byte,
  output logic                  Cin_byte,
  input  logic [7:0]            S_byte,
  input  logic                  Cout_byte,
  output logic [8*NBYTES-1:0]   S_out,
  output logic                  Cout_out,
  output logic                  busy,
  output logic                  done
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [IW+2:0] bit_off;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  s_reg;
  logic          carry;
  logic [W-1:0]  b_cap;
  logic          c_cap;

  // Operand B and initial carry as captured at start (inverted B plus forced
  // carry-in of 1 gives A + ~B + 1 = A - B when subtracting).
  always_comb begin
    b_cap = B_in;
    c_cap = Cin_in;
`ifdef MULTIBYTE_SUB_EN
    if (sub) begin
      b_cap = ~B_in;
      c_cap = 1'b1;
    end
`endif
  end

  assign bit_off = {idx, 3'b000};

  // Control FSM plus operand/result/carry registers; one byte per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            a_reg <= A_in;
            b_reg <= b_cap;
            carry <= c_cap;
            idx   <= '0;
          end
        end
        RUN: begin
          s_reg[bit_off +: 8] <= S_byte;
          carry               <= Cout_byte;
          idx                 <= idx + 1'b1;
          if (idx == LAST) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status and adder-facing outputs; adder inputs are forced to 0 outside RUN.
  always_comb begin
    busy     = (state == RUN);
    done     = (state == DONE);
    A_byte   = busy ? a_reg[bit_off +: 8] : 8'h00;
    B_byte   = busy ? b_reg[bit_off +: 8] : 8'h00;
    Cin_byte = busy & carry;
    S_out    = s_reg;
    Cout_out = carry;
  end

endmodule
